// File: rtl/uart_pkg.sv
// Shared widths and launch-FSM encoding for the UART transmit byte buffer.
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int UART_FIFO_AW = 4;
  localparam int LAUNCH_GUARD = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } launch_state_e;

  // True on the last cycle the launcher will wait for the transmitter to go busy.
  function automatic logic guard_expired(input logic [1:0] guard);
    return guard == 2'(LAUNCH_GUARD - 1);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus-side push port, status flags and transmitter handshake of the UART TX buffer.
interface uart_tx_fifo_if #(
  parameter int DATA_W = uart_pkg::UART_DATA_W,
  parameter int ADDR_W = uart_pkg::UART_FIFO_AW
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              flush;
  logic              ovf_clr;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic              idle;

  modport slave (
    input  wr_en, wr_data, flush, ovf_clr, tx_busy,
    output full, empty, level, overflow, tx_start, tx_data, idle
  );

  modport master (
    output wr_en, wr_data, flush, ovf_clr, tx_busy,
    input  full, empty, level, overflow, tx_start, tx_data, idle
  );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Byte FIFO with a separate level counter; full/empty derive from the level.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);
  localparam int                DEPTH      = 2**ADDR_W;
  localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEVEL_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // Fullness is judged before the edge, so a same-cycle pop never makes room.
  assign full      = (level_r == LEVEL_FULL);
  assign empty     = (level_r == LEVEL_ZERO);
  assign level     = level_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full  & ~flush;
  assign pop_ok_s  = pop  & ~empty & ~flush;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and level bookkeeping.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LEVEL_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LEVEL_ZERO;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit byte buffer: queues bus writes and launches them into
// async_transmitter one at a time whenever it reports idle.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_FIFO_AW
) (
  input logic           clk,
  input logic           clr,
  uart_tx_fifo_if.slave bus
);
  launch_state_e     state_r;
  launch_state_e     state_nx_s;
  logic [1:0]        guard_r;
  logic [1:0]        guard_nx_s;
  logic              launch_s;
  logic              drop_s;
  logic              ovf_nx_s;
  logic              tx_start_r;
  logic              overflow_r;
  logic [DATA_W-1:0] tx_data_r;
  logic [DATA_W-1:0] head_data_s;
  logic [ADDR_W:0]   level_s;
  logic              full_s;
  logic              empty_s;

  sync_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .flush   (bus.flush),
    .push    (bus.wr_en),
    .pop     (launch_s),
    .wr_data (bus.wr_data),
    .rd_data (head_data_s),
    .level   (level_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Launch FSM next state; a byte that never raises busy is abandoned after the guard.
  always_comb begin
    state_nx_s = state_r;
    guard_nx_s = guard_r;
    launch_s   = 1'b0;
    if (bus.flush) begin
      state_nx_s = IDLE;
      guard_nx_s = 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!empty_s && !bus.tx_busy) begin
            launch_s   = 1'b1;
            state_nx_s = WAIT_BUSY;
            guard_nx_s = 2'd0;
          end else begin
            state_nx_s = IDLE;
          end
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state_nx_s = WAIT_DONE;
          end else if (guard_expired(guard_r)) begin
            state_nx_s = IDLE;
          end else begin
            guard_nx_s = guard_r + 2'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state_nx_s = IDLE;
          end else begin
            state_nx_s = WAIT_DONE;
          end
        end
        default: state_nx_s = IDLE;
      endcase
    end
  end

  // Sticky overflow: a dropped push outranks a clear in the same cycle.
  always_comb begin
    drop_s = bus.wr_en & full_s & ~bus.flush;
    if (drop_s) begin
      ovf_nx_s = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_nx_s = 1'b0;
    end else begin
      ovf_nx_s = overflow_r;
    end
  end

  // FSM, launch strobe, held transmit byte and overflow registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r    <= IDLE;
      guard_r    <= 2'd0;
      tx_start_r <= 1'b0;
      tx_data_r  <= {DATA_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      guard_r    <= guard_nx_s;
      tx_start_r <= launch_s;
      overflow_r <= ovf_nx_s;
      if (launch_s) begin
        tx_data_r <= head_data_s;
      end
    end
  end

  assign bus.full     = full_s;
  assign bus.empty    = empty_s;
  assign bus.level    = level_s;
  assign bus.overflow = overflow_r;
  assign bus.tx_start = tx_start_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.idle     = empty_s & (state_r == IDLE) & ~bus.tx_busy;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural transmitter and queue model.
module tb_uart_tx_fifo;
  localparam int MODE_NORMAL = 0;
  localparam int MODE_HOLD   = 1;
  localparam int MODE_MUTE   = 2;

  logic clk;
  logic clr;
  uart_tx_fifo_if bus ();

  uart_tx_fifo dut (.clk(clk), .clr(clr), .bus(bus));

  int         vectors    = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic       model_ovf  = 1'b0;
  logic       busy_at_edge = 1'b0;
  int         n_starts   = 0;
  int         cyc        = 0;
  int         xmit_mode  = MODE_NORMAL;
  int         frame_min  = 1;
  int         frame_max  = 4;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    logic found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.tx_start) begin
        found = 1'b1;
        break;
      end
    end
    check("wait_start_timeout", found, 1);
  endtask

  task automatic wait_drain(input int budget);
    logic done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.idle && !bus.tx_busy) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_timeout", done, 1);
  endtask

  // Reference queue: accepts pushes by the stated rules at each clock edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      busy_at_edge = bus.tx_busy;
      if (!clr) begin
        if (bus.flush) begin
          exp_q.delete();
          if (bus.ovf_clr) model_ovf = 1'b0;
        end else if (bus.wr_en && exp_q.size() >= 16) begin
          model_ovf = 1'b1;
        end else begin
          if (bus.wr_en) exp_q.push_back(bus.wr_data);
          if (bus.ovf_clr) model_ovf = 1'b0;
        end
      end
    end
  end

  // Behavioural async_transmitter: busy for a random frame after each start pulse.
  initial begin
    int frame_cnt = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (xmit_mode == MODE_HOLD) begin
        bus.tx_busy = 1'b1;
        frame_cnt   = 0;
      end else if (xmit_mode == MODE_MUTE) begin
        bus.tx_busy = 1'b0;
        frame_cnt   = 0;
      end else begin
        if (frame_cnt > 0) frame_cnt--;
        if (bus.tx_start) frame_cnt = $urandom_range(frame_max, frame_min);
        bus.tx_busy = (frame_cnt > 0);
      end
    end
  end

  // Monitor: pops the scoreboard on every launch and checks status flags.
  initial begin
    logic       prev_start = 1'b0;
    logic [7:0] exp_byte;
    forever begin
      @(negedge clk);
      if (!clr) begin
        if (bus.tx_start) begin
          n_starts++;
          check("start_pulse_width", prev_start, 0);
          check("start_while_busy", busy_at_edge, 0);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL start_unexpected: got tx_start with byte %0h, expected no launch", bus.tx_data);
          end else begin
            exp_byte = exp_q.pop_front();
            check("tx_data", bus.tx_data, exp_byte);
          end
        end
        check("level", bus.level, exp_q.size());
        check("full", bus.full, exp_q.size() == 16);
        check("empty", bus.empty, exp_q.size() == 0);
        check("overflow", bus.overflow, model_ovf);
      end
      prev_start = bus.tx_start;
    end
  end

  initial begin
    int t1;
    int s0;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.flush = 1'b0; bus.ovf_clr = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    check("rst_level", bus.level, 0);
    check("rst_full", bus.full, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_overflow", bus.overflow, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_idle", bus.idle, 1);
    step();
    clr = 1'b0;
    step();

    // Single byte: written at edge 1, launched at edge 2.
    push_byte(8'h41);
    @(negedge clk);
    check("lat_level1", bus.level, 1);
    check("lat_no_start", bus.tx_start, 0);
    @(negedge clk);
    check("lat_start", bus.tx_start, 1);
    check("lat_data", bus.tx_data, 8'h41);
    check("lat_level0", bus.level, 0);
    @(negedge clk);
    check("lat_pulse_end", bus.tx_start, 0);
    wait_drain(100);
    step();

    // Fill while the transmitter is held busy, then overflow.
    xmit_mode = MODE_HOLD;
    step(); step();
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
    @(negedge clk);
    check("fill_full", bus.full, 1);
    check("fill_level", bus.level, 16);
    step();
    bus.ovf_clr = 1'b1;
    push_byte(8'hFF);
    bus.ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_set_wins", bus.overflow, 1);
    check("ovf_level", bus.level, 16);
    step();
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", bus.overflow, 0);

    // Release busy and push in the same cycle as the launch pop.
    step();
    xmit_mode = MODE_NORMAL;
    push_byte(8'hEE);
    @(negedge clk);
    check("samecyc_start", bus.tx_start, 1);
    check("samecyc_data", bus.tx_data, 8'h10);
    check("samecyc_overflow", bus.overflow, 1);
    check("samecyc_level", bus.level, 15);
    step();
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    @(negedge clk);
    check("samecyc_ovf_clr", bus.overflow, 0);
    wait_drain(400);
    step();

    // Wrap-around: 40 bytes in bursts of 5.
    s0 = n_starts;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 200 && exp_q.size() > 8; k++) step();
      for (int i = 0; i < 5; i++) push_byte(8'(((b * 5 + i) * 3) % 256));
      for (int k = $urandom_range(0, 12); k > 0; k--) step();
    end
    wait_drain(1000);
    check("wrap_count", n_starts - s0, 40);
    check("wrap_level", bus.level, 0);
    check("wrap_idle", bus.idle, 1);
    step();

    // Transmitter never answers: guard expires, next byte still launches.
    xmit_mode = MODE_MUTE;
    step();
    push_byte(8'hA1);
    push_byte(8'hA2);
    wait_start(20);
    t1 = cyc;
    wait_start(20);
    check("guard_spacing", cyc - t1, 5);
    wait_drain(50);
    check("mute_idle", bus.idle, 1);
    xmit_mode = MODE_NORMAL;
    step();

    // Flush with bytes queued while a long frame is on the line.
    frame_min = 25; frame_max = 25;
    for (int i = 0; i < 7; i++) push_byte(8'(8'h20 + i));
    step(); step();
    @(negedge clk);
    check("flush_pre_level", bus.level, 6);
    step();
    s0 = n_starts;
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h77;
    step();
    bus.flush = 1'b0; bus.wr_en = 1'b0;
    @(negedge clk);
    check("flush_level", bus.level, 0);
    check("flush_empty", bus.empty, 1);
    check("flush_overflow", bus.overflow, 0);
    for (int k = 0; k < 40; k++) step();
    check("flush_no_start", n_starts - s0, 0);
    check("flush_idle", bus.idle, 1);

    // Asynchronous clear in the middle of WAIT_DONE.
    push_byte(8'h5A);
    push_byte(8'hA5);
    wait_start(10);
    step(); step(); step();
    s0 = n_starts;
    clr = 1'b1;
    exp_q.delete();
    model_ovf = 1'b0;
    #1;
    check("clr_level", bus.level, 0);
    check("clr_full", bus.full, 0);
    check("clr_empty", bus.empty, 1);
    check("clr_overflow", bus.overflow, 0);
    check("clr_tx_start", bus.tx_start, 0);
    check("clr_tx_data", bus.tx_data, 0);
    check("clr_idle", bus.idle, !bus.tx_busy);
    step();
    clr = 1'b0;
    wait_drain(100);
    check("clr_no_start", n_starts - s0, 0);
    frame_min = 1; frame_max = 4;
    step();

    // Random traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      bus.wr_en   = ($urandom_range(0, 2) == 0);
      bus.wr_data = 8'($urandom);
      bus.ovf_clr = ($urandom_range(0, 15) == 0);
      bus.flush   = ($urandom_range(0, 63) == 0);
      step();
    end
    bus.wr_en = 1'b0; bus.ovf_clr = 1'b0; bus.flush = 1'b0;
    wait_drain(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
